pip1_align_mul: RTL and testbench

Parametrised second pipeline stage of the multi-precision dot-product PE. It takes N lanes of unpacked operands (exponent sum, two mantissas, product sign, zero flag) and finds the maximum exponent. It computes each lane's alignment shift and produces full-width signed mantissa products. It sits between operand unpack (pip0) and the alignment/adder-tree stage (pip2), and adds a valid/ready handshake with backpressure that the fixed 16-lane stage lacked.

---
 rtl/pe_pkg.sv | 20 ++
 rtl/pip1_exp_max_tree.sv | 35 +++
 rtl/pip1_align_mul.sv | 133 +++++++++++++
 tb/tb_pip1_align_mul.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the dot-product PE pipeline: precision mode
// encoding, default operand widths and the flat-bus lane slicing helper.
package pe_pkg;

    typedef enum logic [1:0] {
        MODE_FP16 = 2'b00,
        MODE_FP32 = 2'b01,
        MODE_FP64 = 2'b10,
        MODE_IDLE = 2'b11
    } mode_e;

    localparam int PE_EXP_W = 10;
    localparam int PE_MAN_W = 13;

    // Lane k of a flat bus of width-bit fields starts at bit k*width.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pip1_exp_max_tree.sv
// Combinational log2(N)-level maximum tree over per-lane exponent sums.
// Zero lanes enter the tree as 0, so an all-zero beat yields exp_max = 0.
module pip1_exp_max_tree
    import pe_pkg::*;
#(
    parameter int N     = 16,
    parameter int EXP_W = PE_EXP_W
) (
    input  logic [N-1:0]       zero,
    input  logic [N*EXP_W-1:0] exp_in,
    output logic [EXP_W-1:0]   exp_max
);

    localparam int LVL = (N > 1) ? $clog2(N) : 1;
    localparam int P   = 1 << LVL;

    // Heap layout: node i has children 2i+1 and 2i+2, leaves start at P-1.
    logic [EXP_W-1:0] node [2*P-1];

    genvar i;
    for (i = 0; i < P; i++) begin : g_leaf
        if (i < N) begin : g_lane
            assign node[P-1+i] = zero[i] ? '0 : exp_in[lane_lsb(i, EXP_W) +: EXP_W];
        end else begin : g_pad
            assign node[P-1+i] = '0;
        end
    end

    for (i = 0; i < P-1; i++) begin : g_node
        assign node[i] = (node[2*i+1] > node[2*i+2]) ? node[2*i+1] : node[2*i+2];
    end

    assign exp_max = node[0];

endmodule

// File: rtl/pip1_align_mul.sv
// Second PE pipeline stage: max exponent, per-lane alignment shift and signed
// mantissa products behind a valid/ready output register. PIP1_SKID_EN adds a skid entry.
module pip1_align_mul
    import pe_pkg::*;
#(
    parameter int N         = 16,
    parameter int EXP_W     = PE_EXP_W,
    parameter int MAN_W     = PE_MAN_W,
    parameter int SHIFT_SAT = 2*MAN_W+2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [1:0]             i_mode,
    input  logic [N-1:0]           i_sign,
    input  logic [N-1:0]           i_zero,
    input  logic [N*EXP_W-1:0]     i_exp,
    input  logic [N*MAN_W-1:0]     i_man_a,
    input  logic [N*MAN_W-1:0]     i_man_b,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [1:0]             o_mode,
    output logic [N-1:0]           o_sign,
    output logic [EXP_W-1:0]       o_exp_max,
    output logic [N*EXP_W-1:0]     o_shift,
    output logic [N*(2*MAN_W+1)-1:0] o_prod
);

    localparam int PW = 2*MAN_W + 1;
    localparam int RW = 2 + N + EXP_W + N*EXP_W + N*PW;
    localparam logic [EXP_W-1:0] SAT_V = EXP_W'(SHIFT_SAT);
    localparam logic [RW-1:0] RST_V = {MODE_IDLE, {(RW-2){1'b0}}};

    function automatic logic [EXP_W-1:0] sat_shift(input logic [EXP_W-1:0] d);
        return (d > SAT_V) ? SAT_V : d;
    endfunction

    logic [EXP_W-1:0]   exp_max_p0;
    logic [N*EXP_W-1:0] shift_p0;
    logic [N*PW-1:0]    prod_p0;
    logic [RW-1:0]      res_p0;
    logic [RW-1:0]      res_p1;
    logic               vld_p1;
    logic               out_free;
    logic               accept;

    // ---- p0: combinational compute from the incoming beat ----
    pip1_exp_max_tree #(.N(N), .EXP_W(EXP_W)) u_exp_max_tree (
        .zero    (i_zero),
        .exp_in  (i_exp),
        .exp_max (exp_max_p0)
    );

    genvar k;
    for (k = 0; k < N; k++) begin : g_lane
        localparam int EL = lane_lsb(k, EXP_W);
        localparam int ML = lane_lsb(k, MAN_W);
        localparam int PL = lane_lsb(k, PW);

        logic [MAN_W-1:0]     a;
        logic [MAN_W-1:0]     b;
        logic [2*MAN_W-1:0]   mag;
        logic signed [PW-1:0] prod;

        // Zero lanes feed 0 into the multiplier so garbage mantissas never propagate.
        assign a    = i_zero[k] ? '0 : i_man_a[ML +: MAN_W];
        assign b    = i_zero[k] ? '0 : i_man_b[ML +: MAN_W];
        assign mag  = {{MAN_W{1'b0}}, a} * {{MAN_W{1'b0}}, b};
        assign prod = signed'({1'b0, mag});

        assign shift_p0[EL +: EXP_W] = i_zero[k] ? SAT_V
                                                 : sat_shift(exp_max_p0 - i_exp[EL +: EXP_W]);
        assign prod_p0[PL +: PW]     = i_zero[k] ? '0 : (i_sign[k] ? -prod : prod);
    end

    assign res_p0   = {i_mode, i_sign, exp_max_p0, shift_p0, prod_p0};
    assign out_free = !vld_p1 || m_ready;

    // ---- p1: output register and handshake ----
`ifdef PIP1_SKID_EN
    logic          skid_vld;
    logic          rdy_q;
    logic [RW-1:0] skid_res;

    assign s_ready = rdy_q;
    assign accept  = s_valid && rdy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1   <= 1'b0;
            res_p1   <= RST_V;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else if (out_free) begin
            if (skid_vld) begin
                // rdy_q is low while the skid is full, so no new beat competes here.
                res_p1   <= skid_res;
                vld_p1   <= 1'b1;
                skid_vld <= 1'b0;
                rdy_q    <= 1'b1;
            end else begin
                vld_p1 <= accept;
                if (accept) res_p1 <= res_p0;
            end
        end else if (accept) begin
            skid_vld <= 1'b1;
            rdy_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!out_free && accept) skid_res <= res_p0;
    end
`else
    assign s_ready = out_free;
    assign accept  = s_valid && out_free;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            res_p1 <= RST_V;
        end else if (out_free) begin
            vld_p1 <= accept;
            if (accept) res_p1 <= res_p0;
        end
    end
`endif

    assign m_valid = vld_p1;
    assign {o_mode, o_sign, o_exp_max, o_shift, o_prod} = res_p1;

endmodule

// File: tb/tb_pip1_align_mul.sv
// Scoreboard bench for pip1_align_mul: directed beats, backpressure, reset mid-stall
// and randomized traffic checked against an arithmetic reference model.
module tb_pip1_align_mul;
    import pe_pkg::*;

    localparam int N     = 16;
    localparam int EXP_W = 10;
    localparam int MAN_W = 13;
    localparam int SAT   = 2*MAN_W + 2;
    localparam int PW    = 2*MAN_W + 1;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 s_valid;
    logic                 s_ready;
    logic [1:0]           i_mode;
    logic [N-1:0]         i_sign;
    logic [N-1:0]         i_zero;
    logic [N*EXP_W-1:0]   i_exp;
    logic [N*MAN_W-1:0]   i_man_a;
    logic [N*MAN_W-1:0]   i_man_b;
    logic                 m_valid;
    logic                 m_ready;
    logic [1:0]           o_mode;
    logic [N-1:0]         o_sign;
    logic [EXP_W-1:0]     o_exp_max;
    logic [N*EXP_W-1:0]   o_shift;
    logic [N*PW-1:0]      o_prod;

    typedef struct {
        logic [1:0]         mode;
        logic [N-1:0]       sign;
        logic [EXP_W-1:0]   emax;
        logic [N*EXP_W-1:0] shift;
        logic [N*PW-1:0]    prod;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   npop  = 0;

    pip1_align_mul #(.N(N), .EXP_W(EXP_W), .MAN_W(MAN_W), .SHIFT_SAT(SAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .i_mode    (i_mode),
        .i_sign    (i_sign),
        .i_zero    (i_zero),
        .i_exp     (i_exp),
        .i_man_a   (i_man_a),
        .i_man_b   (i_man_b),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .o_mode    (o_mode),
        .o_sign    (o_sign),
        .o_exp_max (o_exp_max),
        .o_shift   (o_shift),
        .o_prod    (o_prod)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: max over live lanes, clamped difference, signed integer product.
    function automatic exp_t model();
        exp_t   e;
        int     mx = 0;
        int     d;
        longint p;
        for (int k = 0; k < N; k++)
            if (!i_zero[k] && int'(i_exp[k*EXP_W +: EXP_W]) > mx) mx = int'(i_exp[k*EXP_W +: EXP_W]);
        e.mode  = i_mode;
        e.sign  = i_sign;
        e.emax  = EXP_W'(mx);
        e.shift = '0;
        e.prod  = '0;
        for (int k = 0; k < N; k++) begin
            if (i_zero[k]) begin
                d = SAT;
                p = 0;
            end else begin
                d = mx - int'(i_exp[k*EXP_W +: EXP_W]);
                if (d > SAT) d = SAT;
                p = longint'(i_man_a[k*MAN_W +: MAN_W]) * longint'(i_man_b[k*MAN_W +: MAN_W]);
                if (i_sign[k]) p = -p;
            end
            e.shift[k*EXP_W +: EXP_W] = EXP_W'(d);
            e.prod[k*PW +: PW]        = p[PW-1:0];
        end
        return e;
    endfunction

    // Monitor: a beat leaves at the next rising edge whenever valid && ready here.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat actual=1 required=0");
            end else begin
                mon_e = sbq.pop_front();
                npop++;
                chk("sb_mode", o_mode, mon_e.mode);
                chk("sb_sign", o_sign, mon_e.sign);
                chk("sb_exp_max", o_exp_max, mon_e.emax);
                chk("sb_shift", o_shift, mon_e.shift);
                chk("sb_prod", o_prod, mon_e.prod);
            end
        end
    end

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = rstn && s_valid && s_ready;
        if (acc) sbq.push_back(model());
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input int e, input int a, input int b);
        i_exp[k*EXP_W +: EXP_W]   = EXP_W'(e);
        i_man_a[k*MAN_W +: MAN_W] = MAN_W'(a);
        i_man_b[k*MAN_W +: MAN_W] = MAN_W'(b);
    endtask

    task automatic rand_inputs();
        int base   = $urandom_range(0, 983);
        bit narrow = 1'($urandom_range(0, 1));
        i_mode = 2'($urandom);
        i_sign = N'($urandom);
        for (int k = 0; k < N; k++) begin
            i_zero[k] = ($urandom_range(0, 3) == 0);
            if (i_zero[k] && $urandom_range(0, 1) == 1) begin
                i_exp[k*EXP_W +: EXP_W]   = 'x;
                i_man_a[k*MAN_W +: MAN_W] = 'x;
                i_man_b[k*MAN_W +: MAN_W] = 'x;
            end else begin
                set_lane(k, narrow ? base + int'($urandom_range(0, 40)) : int'($urandom_range(0, 1023)),
                         int'($urandom), int'($urandom));
            end
        end
        if ($urandom_range(0, 49) == 0) i_zero = '1;
    endtask

    task automatic drain(input string nm);
        bit acc;
        int c = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while ((sbq.size() != 0 || m_valid) && c < 40) begin
            tick(acc);
            c++;
        end
        chk(nm, sbq.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int nacc;
        int c;
        int npop0;

        s_valid = 1'b0; m_ready = 1'b0; i_mode = 2'b00;
        i_sign = '0; i_zero = '0; i_exp = '0; i_man_a = '0; i_man_b = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_mode", o_mode, MODE_IDLE);
        chk("rst_sign", o_sign, 0);
        chk("rst_exp_max", o_exp_max, 0);
        chk("rst_shift", o_shift, 0);
        chk("rst_prod", o_prod, 0);
        rstn = 1'b1;
        tick(acc);
        chk("rst_s_ready", s_ready, 1);

        // Exponent compare and product/sign
        m_ready = 1'b1; s_valid = 1'b1; i_mode = MODE_FP32;
        i_zero = '0; i_sign = '0; i_sign[3] = 1'b1;
        for (int k = 0; k < N; k++) set_lane(k, 90, 7, 9);
        set_lane(0, 100, 4096, 4096);
        set_lane(3, 90, 3, 5);
        set_lane(5, 120, 11, 13);
        tick(acc);
        s_valid = 1'b0;
        chk("dir_accept", acc, 1);
        chk("dir_exp_max", o_exp_max, 120);
        chk("dir_shift0", o_shift[0 +: EXP_W], 20);
        chk("dir_shift5", o_shift[5*EXP_W +: EXP_W], 0);
        chk("dir_shift1_clamp", o_shift[1*EXP_W +: EXP_W], 28);
        chk("dir_prod0", o_prod[0 +: PW], 27'd16777216);
        chk("dir_prod3_neg", o_prod[3*PW +: PW], 27'h7FFFFF1);
        chk("dir_mode", o_mode, MODE_FP32);
        drain("dir_drain");

        // Zero masking: all lanes zero
        s_valid = 1'b1; i_zero = '1; i_sign = '1;
        for (int k = 0; k < N; k++) set_lane(k, 500, 8191, 8191);
        tick(acc);
        s_valid = 1'b0;
        chk("zero_all_exp_max", o_exp_max, 0);
        chk("zero_all_shift", o_shift, {N{10'd28}});
        chk("zero_all_prod", o_prod, 0);
        drain("zero_all_drain");

        // Only lane 7 live
        s_valid = 1'b1; i_zero = ~(16'h0001 << 7); i_sign = '0;
        set_lane(7, 42, 100, 3);
        tick(acc);
        s_valid = 1'b0;
        chk("zero_one_exp_max", o_exp_max, 42);
        chk("zero_one_shift7", o_shift[7*EXP_W +: EXP_W], 0);
        chk("zero_one_shift0", o_shift[0 +: EXP_W], 28);
        chk("zero_one_prod7", o_prod[7*PW +: PW], 300);
        drain("zero_one_drain");

        // Backpressure: D1..D4 offered back-to-back, output stalled 3 cycles
        npop0 = npop; nacc = 0; c = 0;
        while (nacc < 4 && c < 30) begin
            m_ready = (c >= 3);
            s_valid = 1'b1;
            rand_inputs();
            i_mode = 2'(nacc);
            tick(acc);
            c++;
            if (acc) begin
                nacc++;
`ifdef PIP1_SKID_EN
                if (nacc == 1) chk("bp_ready_after_d1", s_ready, 1);
                if (nacc == 2) chk("bp_ready_fall_d2", s_ready, 0);
`else
                if (nacc == 1) chk("bp_ready_after_d1", s_ready, 0);
`endif
            end
        end
        chk("bp_accepted", nacc, 4);
        drain("bp_drain");
        chk("bp_once", npop - npop0, 4);

        // Reset while beats are held
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            rand_inputs();
            tick(acc);
        end
        rstn = 1'b0; s_valid = 1'b0;
        #1;
        sbq.delete();
        chk("mr_m_valid", m_valid, 0);
        chk("mr_mode", o_mode, MODE_IDLE);
        chk("mr_data", |{o_sign, o_exp_max, o_shift, o_prod}, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1; m_ready = 1'b1;
        tick(acc);
        chk("mr_s_ready", s_ready, 1);
        repeat (3) tick(acc);
        chk("mr_idle", m_valid, 0);

        // Randomized traffic
        nacc = 0; c = 0;
        while (nacc < 10000 && c < 60000) begin
            s_valid = ($urandom_range(0, 9) < 7);
            m_ready = ($urandom_range(0, 9) < 7);
            rand_inputs();
            tick(acc);
            if (acc) nacc++;
            c++;
        end
        chk("rand_accepted", nacc, 10000);
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
